// File: rtl/pin_input_debouncer_pkg.sv
// pin_input_pkg: shared state encoding and counter width helpers for board input pins
package pin_input_pkg;
  typedef enum logic [1:0] {RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE} state_t;
  function automatic int db_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int hold_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pin_input_debouncer_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous board input pin
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= {2{RESET_VAL}};
    else {q, m} <= {m, d};
endmodule

// File: rtl/pin_input_debouncer.sv
// pin_input_debouncer: debounced level, edge pulses, long-press pulse and press counter for one pin
module pin_input_debouncer
  import pin_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 16000,
  parameter int LONG_PRESS_CYCLES = 16000000,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int CNT_W             = 8
) (
  input  logic             pin3_clk_16mhz,
  input  logic             rst,
  input  logic             pin_in,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             long_press,
  output logic [CNT_W-1:0] press_count
);
  localparam int DW = db_w(DEBOUNCE_CYCLES);
  localparam int HW = hold_w(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 2);
  state_t          state;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            s, p;
  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk(pin3_clk_16mhz),
    .rst(rst),
    .d  (pin_in),
    .q  (s)
  );
  assign p = s ^ ACTIVE_LOW;
  // hold_cnt saturates so long_press can only fire on the single L-2 -> L-1 step
  always_ff @(posedge pin3_clk_16mhz)
    if (rst) begin
      state       <= RELEASED;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      level       <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
      long_press  <= 1'b0;
      press_count <= '0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      long_press <= 1'b0;
      case (state)
        RELEASED:
          if (p) begin
            state  <= CHECK_PRESS;
            db_cnt <= DW'(1);
          end
        CHECK_PRESS:
          if (!p) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state       <= PRESSED;
            db_cnt      <= '0;
            level       <= 1'b1;
            rise_pulse  <= 1'b1;
            press_count <= press_count + 1'b1;
            hold_cnt    <= '0;
          end else db_cnt <= db_cnt + 1'b1;
        PRESSED: begin
          if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          long_press <= hold_cnt == HOLD_FIRE;
          if (!p) begin
            state  <= CHECK_RELEASE;
            db_cnt <= DW'(1);
          end
        end
        CHECK_RELEASE:
          if (p) begin
            state  <= PRESSED;
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state      <= RELEASED;
            db_cnt     <= '0;
            level      <= 1'b0;
            fall_pulse <= 1'b1;
          end else db_cnt <= db_cnt + 1'b1;
        default: state <= RELEASED;
      endcase
    end
endmodule

// File: tb/tb_pin_input_debouncer.sv
// tb_pin_input_debouncer: random and directed stimulus checked against a run-length model of the debouncer
module tb_pin_input_debouncer;
  localparam int D = 4;
  localparam int L = 20;
  localparam int W = 3;
  logic clk = 1'b0, rst = 1'b1, pin_in = 1'b1;
  logic level, rise_pulse, fall_pulse, long_press;
  logic [W-1:0] press_count;
  int checks = 0, fails = 0;
  pin_input_debouncer #(
    .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1), .CNT_W(W)
  ) dut (
    .pin3_clk_16mhz(clk),
    .rst(rst),
    .pin_in(pin_in),
    .level(level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .long_press(long_press),
    .press_count(press_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a level change is accepted after D consecutive synchronised samples disagreeing with it
  bit en = 0, m_s1, m_s2, m_level, p, in_press;
  int m_run, m_hold, m_cnt;
  bit e_rise, e_fall, e_long;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_level = 0; m_run = 0; m_hold = 0; m_cnt = 0;
      e_rise = 0; e_fall = 0; e_long = 0; en = 1;
    end else begin
      p = !m_s2;
      m_s2 = m_s1;
      m_s1 = pin_in;
      e_rise = 0; e_fall = 0; e_long = 0;
      in_press = m_level && m_run == 0;
      if (in_press && m_hold < L) begin
        m_hold++;
        e_long = (m_hold == L - 1);
      end
      if (p != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = p;
          m_run = 0;
          if (p) begin
            e_rise = 1;
            m_cnt = (m_cnt + 1) % (1 << W);
            m_hold = 0;
          end else e_fall = 1;
        end
      end else m_run = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (en) begin
      chk("level", level, m_level);
      chk("rise_pulse", rise_pulse, e_rise);
      chk("fall_pulse", fall_pulse, e_fall);
      chk("long_press", long_press, e_long);
      chk("press_count", press_count, m_cnt);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_for(input int sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((sel == 0 && rise_pulse) || (sel == 1 && fall_pulse) || (sel == 2 && long_press)) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int n, nl, nf, nr, first, len;
    rst = 1; pin_in = 1;
    repeat (10) tick();
    chk("reset_level", level, 0);
    chk("reset_rise", rise_pulse, 0);
    chk("reset_count", press_count, 0);
    rst = 0;
    tick();
    nr = 0;
    for (int i = 0; i < 18; i++) begin
      pin_in = (i < 3 || i == 4 || i == 5) ? 1'b0 : 1'b1;
      tick();
      if (rise_pulse) nr++;
    end
    chk("bounce_rise", nr, 0);
    chk("bounce_level", level, 0);
    pin_in = 0;
    wait_for(0, 20, n);
    chk("rise_latency", n, 6);
    chk("press_level", level, 1);
    chk("press_count1", press_count, 1);
    first = -1; nl = 0; nf = 0;
    for (int c = 1; c <= 40; c++) begin
      pin_in = (c == 25 || c == 26);
      tick();
      if (long_press) begin
        nl++;
        if (first < 0) first = c;
      end
      if (fall_pulse) nf++;
    end
    chk("long_at", first, 19);
    chk("long_count", nl, 1);
    chk("glitch_fall", nf, 0);
    chk("hold_level", level, 1);
    pin_in = 1;
    wait_for(1, 20, n);
    chk("fall_latency", n, 6);
    chk("release_level", level, 0);
    rst = 1; tick(); rst = 0; tick();
    for (int k = 0; k < 9; k++) begin
      pin_in = 0;
      repeat (10) tick();
      chk("wrap_count", press_count, (k + 1) % 8);
      pin_in = 1;
      repeat (10) tick();
    end
    pin_in = 0;
    repeat (10) tick();
    chk("pre_rst_level", level, 1);
    rst = 1;
    tick();
    chk("rst_level", level, 0);
    chk("rst_fall", fall_pulse, 0);
    chk("rst_count", press_count, 0);
    rst = 0;
    wait_for(0, 20, n);
    chk("rst_rise_latency", n, 6);
    chk("rst_count1", press_count, 1);
    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1; tick(); rst = 0;
      end
      pin_in = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 7);
      repeat (len) tick();
    end
    pin_in = 1;
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
